// File: rtl/mem_access_unit.sv
// ME-stage data memory access unit: drives a request/response data bus, sign/zero-extends loads.
// Optional misalignment trapping is enabled by defining MEM_ALIGN_CHECK_EN.
//
// Handshake: data_req is held high, with every bus output constant, until data_addr_ok;
// the response arrives with data_data_ok in the same cycle or in any later cycle.
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        memen,
  input  logic [2:0]  memop,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        flush,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        adel,
  output logic        ades,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  output logic [3:0]  data_wstrb,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic [2:0]  dbgState
);

  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LBU = 3'b001;
  localparam logic [2:0] OP_LH  = 3'b010;
  localparam logic [2:0] OP_LHU = 3'b011;
  localparam logic [2:0] OP_LW  = 3'b100;
  localparam logic [2:0] OP_SB  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SW  = 3'b111;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t      state, stateNext;
  logic [2:0]  opReg;
  logic [31:0] addrReg;
  logic [31:0] wdataReg;

  logic        isStoreIn;
  logic        isHalfIn;
  logic        isWordIn;
  logic [31:0] alignedAddr;
  logic        addrOk;
  logic        startReq;
  logic        opIsStore;
  logic        loadCapture;
  logic [31:0] laneWord;
  logic [31:0] loadExt;

  assign dbgState = state;

  // Decode of the incoming ME-stage instruction, only meaningful in IDLE.
  always_comb begin
    isStoreIn = (memop == OP_SB) || (memop == OP_SH) || (memop == OP_SW);
    isHalfIn  = (memop == OP_LH) || (memop == OP_LHU) || (memop == OP_SH);
    isWordIn  = (memop == OP_LW) || (memop == OP_SW);
    alignedAddr = addr;
    if (isHalfIn) alignedAddr = {addr[31:1], 1'b0};
    if (isWordIn) alignedAddr = {addr[31:2], 2'b00};
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic misaligned;
  logic alignFault;
  assign misaligned = (isHalfIn && addr[0]) || (isWordIn && (addr[1:0] != 2'b00));
  assign addrOk     = !misaligned;
  // Flags are gated by rst so they read zero while reset is asserted.
  assign alignFault = rst && (state == IDLE) && memen && misaligned;
  assign adel       = alignFault && !isStoreIn;
  assign ades       = alignFault && isStoreIn;
`else
  assign addrOk = 1'b1;
  assign adel   = 1'b0;
  assign ades   = 1'b0;
`endif

  assign startReq  = memen && !flush && addrOk;
  assign opIsStore = (opReg == OP_SB) || (opReg == OP_SH) || (opReg == OP_SW);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= stateNext;
  end

  // Next-state logic; a flushed access whose response lands is retired without writing rdata.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (startReq) stateNext = REQ;
      REQ: begin
        if (data_addr_ok) begin
          if (flush)             stateNext = data_data_ok ? IDLE : DRAIN;
          else if (data_data_ok) stateNext = DONE;
          else                   stateNext = WAIT;
        end else if (flush) begin
          stateNext = IDLE;
        end
      end
      WAIT: begin
        if (flush)             stateNext = data_data_ok ? IDLE : DRAIN;
        else if (data_data_ok) stateNext = DONE;
      end
      DRAIN: if (data_data_ok) stateNext = IDLE;
      DONE:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    stall    = 1'b0;
    data_req = 1'b0;
    case (state)
      IDLE:  stall = rst && startReq;
      REQ: begin
        stall    = 1'b1;
        data_req = 1'b1;
      end
      WAIT:  stall = 1'b1;
      DRAIN: stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  // Request copy, captured once so the bus sees stable values for the whole transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      opReg    <= OP_LB;
      addrReg  <= '0;
      wdataReg <= '0;
    end else if ((state == IDLE) && startReq) begin
      opReg    <= memop;
      addrReg  <= alignedAddr;
      wdataReg <= wdata;
    end
  end

  // Bus outputs are driven only while a request is active, zero otherwise.
  always_comb begin
    data_wr    = 1'b0;
    data_size  = 2'd0;
    data_addr  = '0;
    data_wdata = '0;
    data_wstrb = 4'b0000;
    if (data_req) begin
      data_addr = addrReg;
      data_wr   = opIsStore;
      case (opReg)
        OP_LB, OP_LBU: data_size = 2'd0;
        OP_LH, OP_LHU: data_size = 2'd1;
        OP_LW:         data_size = 2'd2;
        OP_SB: begin
          data_size  = 2'd0;
          data_wdata = {4{wdataReg[7:0]}};
          data_wstrb = 4'b0001 << addrReg[1:0];
        end
        OP_SH: begin
          data_size  = 2'd1;
          data_wdata = {2{wdataReg[15:0]}};
          data_wstrb = 4'b0011 << {addrReg[1], 1'b0};
        end
        default: begin
          data_size  = 2'd2;
          data_wdata = wdataReg;
          data_wstrb = 4'b1111;
        end
      endcase
    end
  end

  // Load lane selection and extension.
  assign laneWord = data_rdata >> {addrReg[1:0], 3'b000};

  always_comb begin
    case (opReg)
      OP_LB:   loadExt = {{24{laneWord[7]}}, laneWord[7:0]};
      OP_LBU:  loadExt = {24'd0, laneWord[7:0]};
      OP_LH:   loadExt = {{16{laneWord[15]}}, laneWord[15:0]};
      OP_LHU:  loadExt = {16'd0, laneWord[15:0]};
      default: loadExt = data_rdata;
    endcase
  end

  assign loadCapture = !opIsStore && !flush &&
                       (((state == REQ) && data_addr_ok && data_data_ok) ||
                        ((state == WAIT) && data_data_ok));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             rdata <= '0;
    else if (loadCapture) rdata <= loadExt;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit: loads, stores, flush/drain, alignment, reset.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        memen;
  logic [2:0]  memop;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        flush;
  logic [31:0] rdata;
  logic        stall;
  logic        adel;
  logic        ades;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic [2:0]  dbgState;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  int numChecks = 0;
  int numFails  = 0;
  logic [31:0] expQ[$];
  logic [31:0] lastRdata;

  mem_access_unit dut (
    .clk(clk), .rst(rst), .memen(memen), .memop(memop), .addr(addr), .wdata(wdata),
    .flush(flush), .rdata(rdata), .stall(stall), .adel(adel), .ades(ades),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_wstrb(data_wstrb), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata), .dbgState(dbgState)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    numChecks++;
    if (obs !== exp) begin
      numFails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Zero-wait access: addr_ok and data_ok both in the REQ cycle.
  task automatic quickAccess(input string tag, input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] rd,
                             input logic [31:0] expAddr, input logic [1:0] expSize,
                             input logic [3:0] expStrb, input logic [31:0] expWdata,
                             input logic [31:0] expRdata);
    logic isStore;
    isStore = (op >= 3'd5);
    expQ.push_back(expRdata);
    tick();
    memen = 1'b1; memop = op; addr = a; wdata = wd;
    #4;
    checkVal({tag, ".idleStall"}, {31'd0, stall}, 32'd1);
    checkVal({tag, ".idleReq"}, {31'd0, data_req}, 32'd0);
    tick();
    data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = rd;
    #4;
    checkVal({tag, ".reqState"}, {29'd0, dbgState}, {29'd0, S_REQ});
    checkVal({tag, ".reqStall"}, {31'd0, stall}, 32'd1);
    checkVal({tag, ".req"}, {31'd0, data_req}, 32'd1);
    checkVal({tag, ".wr"}, {31'd0, data_wr}, {31'd0, isStore});
    checkVal({tag, ".addr"}, data_addr, expAddr);
    checkVal({tag, ".size"}, {30'd0, data_size}, {30'd0, expSize});
    checkVal({tag, ".strb"}, {28'd0, data_wstrb}, {28'd0, expStrb});
    if (isStore) checkVal({tag, ".wdata"}, data_wdata, expWdata);
    tick();
    data_addr_ok = 1'b0; data_data_ok = 1'b0; memen = 1'b0;
    #4;
    checkVal({tag, ".doneState"}, {29'd0, dbgState}, {29'd0, S_DONE});
    checkVal({tag, ".doneStall"}, {31'd0, stall}, 32'd0);
    checkVal({tag, ".rdata"}, rdata, expQ.pop_front());
    lastRdata = expRdata;
  endtask

  initial begin
    rst = 1'b0; memen = 1'b1; memop = 3'b100; addr = 32'h102; wdata = '0; flush = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
    lastRdata = '0;
    repeat (2) tick();
    #4;
    checkVal("rst.state", {29'd0, dbgState}, {29'd0, S_IDLE});
    checkVal("rst.stall", {31'd0, stall}, 32'd0);
    checkVal("rst.adel", {31'd0, adel}, 32'd0);
    checkVal("rst.ades", {31'd0, ades}, 32'd0);
    checkVal("rst.req", {31'd0, data_req}, 32'd0);
    checkVal("rst.wr", {31'd0, data_wr}, 32'd0);
    checkVal("rst.strb", {28'd0, data_wstrb}, 32'd0);
    checkVal("rst.size", {30'd0, data_size}, 32'd0);
    checkVal("rst.addr", data_addr, 32'd0);
    checkVal("rst.wdata", data_wdata, 32'd0);
    checkVal("rst.rdata", rdata, 32'd0);
    memen = 1'b0;
    tick();
    rst = 1'b1;

    quickAccess("lw100",  3'b100, 32'h100, 32'h0, 32'hDEADBEEF, 32'h100, 2'd2, 4'b0000, 32'h0, 32'hDEADBEEF);
    quickAccess("lb103",  3'b000, 32'h103, 32'h0, 32'h80112233, 32'h103, 2'd0, 4'b0000, 32'h0, 32'hFFFFFF80);
    quickAccess("lbu103", 3'b001, 32'h103, 32'h0, 32'h80112233, 32'h103, 2'd0, 4'b0000, 32'h0, 32'h00000080);
    quickAccess("lh102",  3'b010, 32'h102, 32'h0, 32'h80112233, 32'h102, 2'd1, 4'b0000, 32'h0, 32'hFFFF8011);
    quickAccess("lhu100", 3'b011, 32'h100, 32'h0, 32'h1234F00D, 32'h100, 2'd1, 4'b0000, 32'h0, 32'h0000F00D);
    quickAccess("lh100",  3'b010, 32'h100, 32'h0, 32'h1234F00D, 32'h100, 2'd1, 4'b0000, 32'h0, 32'hFFFFF00D);
    quickAccess("lb101",  3'b000, 32'h101, 32'h0, 32'h1234F00D, 32'h101, 2'd0, 4'b0000, 32'h0, 32'hFFFFFFF0);
    quickAccess("sb201",  3'b101, 32'h201, 32'h000000AB, 32'h0, 32'h201, 2'd0, 4'b0010, 32'hABABABAB, 32'hFFFFFFF0);
    quickAccess("sh202",  3'b110, 32'h202, 32'h0000BEEF, 32'h0, 32'h202, 2'd1, 4'b1100, 32'hBEEFBEEF, 32'hFFFFFFF0);
    quickAccess("sw204",  3'b111, 32'h204, 32'h12345678, 32'h0, 32'h204, 2'd2, 4'b1111, 32'h12345678, 32'hFFFFFFF0);

    // Flush while REQ has not been accepted: request withdrawn.
    tick();
    memen = 1'b1; memop = 3'b100; addr = 32'h600;
    tick();
    flush = 1'b1;
    #4;
    checkVal("flushReq.req", {31'd0, data_req}, 32'd1);
    tick();
    flush = 1'b0; memen = 1'b0;
    #4;
    checkVal("flushReq.state", {29'd0, dbgState}, {29'd0, S_IDLE});
    checkVal("flushReq.reqOff", {31'd0, data_req}, 32'd0);
    checkVal("flushReq.rdata", rdata, lastRdata);

    // Flush in WAIT: drain the accepted transaction, rdata untouched.
    tick();
    memen = 1'b1; memop = 3'b100; addr = 32'h300;
    tick();
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0; flush = 1'b1;
    #4;
    checkVal("drain.waitState", {29'd0, dbgState}, {29'd0, S_WAIT});
    checkVal("drain.waitReq", {31'd0, data_req}, 32'd0);
    checkVal("drain.waitStall", {31'd0, stall}, 32'd1);
    tick();
    flush = 1'b0; memen = 1'b0;
    #4;
    checkVal("drain.state", {29'd0, dbgState}, {29'd0, S_DRAIN});
    checkVal("drain.stall3", {31'd0, stall}, 32'd1);
    tick();
    #4;
    checkVal("drain.stall4", {31'd0, stall}, 32'd1);
    tick();
    data_data_ok = 1'b1; data_rdata = 32'hCAFEF00D;
    #4;
    checkVal("drain.stall5", {31'd0, stall}, 32'd1);
    tick();
    data_data_ok = 1'b0;
    #4;
    checkVal("drain.idle", {29'd0, dbgState}, {29'd0, S_IDLE});
    checkVal("drain.stall6", {31'd0, stall}, 32'd0);
    checkVal("drain.rdata", rdata, lastRdata);

    // Misaligned word load.
`ifdef MEM_ALIGN_CHECK_EN
    tick();
    memen = 1'b1; memop = 3'b100; addr = 32'h102;
    #4;
    checkVal("mis.adel", {31'd0, adel}, 32'd1);
    checkVal("mis.ades", {31'd0, ades}, 32'd0);
    checkVal("mis.stall", {31'd0, stall}, 32'd0);
    tick();
    #4;
    checkVal("mis.state", {29'd0, dbgState}, {29'd0, S_IDLE});
    checkVal("mis.req", {31'd0, data_req}, 32'd0);
    memop = 3'b111; addr = 32'h101;
    #1;
    checkVal("misSw.ades", {31'd0, ades}, 32'd1);
    checkVal("misSw.adel", {31'd0, adel}, 32'd0);
    memen = 1'b0;
`else
    tick();
    memen = 1'b1; memop = 3'b110; addr = 32'h203;
    #4;
    checkVal("mis.adel", {31'd0, adel}, 32'd0);
    checkVal("mis.ades", {31'd0, ades}, 32'd0);
    memen = 1'b0;
    quickAccess("lw102", 3'b100, 32'h102, 32'h0, 32'h55667788, 32'h100, 2'd2, 4'b0000, 32'h0, 32'h55667788);
    quickAccess("sh203", 3'b110, 32'h203, 32'h00001234, 32'h0, 32'h202, 2'd1, 4'b1100, 32'h12341234, 32'h55667788);
`endif

    // Reset asserted in WAIT, then a stale response must be ignored.
    tick();
    memen = 1'b1; memop = 3'b100; addr = 32'h400;
    tick();
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    checkVal("rstWait.state", {29'd0, dbgState}, {29'd0, S_IDLE});
    checkVal("rstWait.stall", {31'd0, stall}, 32'd0);
    checkVal("rstWait.req", {31'd0, data_req}, 32'd0);
    checkVal("rstWait.rdata", rdata, 32'd0);
    checkVal("rstWait.addr", data_addr, 32'd0);
    memen = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h99999999;
    tick();
    rst = 1'b1;
    tick();
    #4;
    checkVal("stale.state", {29'd0, dbgState}, {29'd0, S_IDLE});
    checkVal("stale.rdata", rdata, 32'd0);
    data_data_ok = 1'b0;
    quickAccess("lw500", 3'b100, 32'h500, 32'h0, 32'h11223344, 32'h500, 2'd2, 4'b0000, 32'h0, 32'h11223344);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have no parameters; all widths fixed at 32-bit address/data.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 memen  in  1  ME-stage instruction accesses memory; inputs held stable by pipeline while stall=1.
REQ-005 memop  in  3  000 LB, 001 LBU, 010 LH, 011 LHU, 100 LW, 101 SB, 110 SH, 111 SW.
REQ-006 addr  in  32  effective address (ALU result, ME stage).
REQ-007 wdata  in  32  store data (rt, ME stage).
REQ-008 flush  in  1  cancel current ME instruction (exception/flush).
REQ-009 rdata  out  32  extended load result, registered.
REQ-010 stall  out  1  hold IF..ME stages; feeds hazard unit.
REQ-011 adel / ades  out  1 each  load / store address error.
REQ-012 data_req, data_wr  out  1  bus request valid; 1=write.
REQ-013 data_size  out  2  0 byte, 1 half, 2 word.
REQ-014 data_addr, data_wdata  out  32 each; data_wstrb  out  4  byte enables.
REQ-015 data_addr_ok, data_data_ok  in  1  address accepted; read data / write ack valid.
REQ-016 data_rdata  in  32  bus read data, valid with data_data_ok.

Function
REQ-017 States SHALL be IDLE, REQ, WAIT, DONE, DRAIN, in a registered FSM.
REQ-018 IDLE: memen=1, flush=0, aligned -> REQ; else stay IDLE.
REQ-019 REQ: data_req=1, all bus outputs held constant from registered copies of memop/addr/wdata.
- addr_ok & data_ok same cycle -> DONE.
- addr_ok only -> WAIT.
- flush without addr_ok -> IDLE, request withdrawn.
REQ-020 WAIT: data_req=0. data_data_ok -> DONE; flush seen in WAIT -> DRAIN.
REQ-021 DRAIN: stall=1; on data_data_ok -> IDLE with rdata unchanged; the accepted transaction is never abandoned.
REQ-022 DONE: one cycle, stall=0, then -> IDLE.
REQ-023 stall SHALL be combinational.
- 1 in IDLE when memen & ~flush & aligned.
- 1 in REQ, WAIT, DRAIN.
- 0 in DONE and otherwise.
REQ-024 Minimum latency: memen at T -> REQ at T+1 -> DONE at T+2; stall high T..T+1, low T+2.
REQ-025 Loads: on data_data_ok in REQ/WAIT, rdata <= extension of the lane selected by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW whole word; stores leave rdata unchanged.
REQ-026 Stores: data_wr=1.
- SB: data_wdata={4{wdata[7:0]}}, strobe 0001<<addr[1:0].
- SH: data_wdata={2{wdata[15:0]}}, strobe 0011<<{addr[1],1'b0}.
- SW: data_wdata=wdata, strobe 1111.
- Loads: strobe 0000.
REQ-027 data_addr SHALL equal addr with no translation.
REQ-028 Outputs other than data_req SHALL be don't-care when data_req=0, except stall, rdata, adel, ades.

Reset
REQ-029 rst low, at any state including mid-transaction:
- FSM -> IDLE.
- data_req=0, data_wr=0, data_wstrb=0, data_size=0.
- data_addr=0, data_wdata=0, rdata=0.
- adel=ades=0, stall=0.
REQ-030 After reset, a response left over from the interrupted transaction SHALL NOT be accepted by the unit; the bus is reset together with the unit.

Configuration
REQ-031 Macro MEM_ALIGN_CHECK_EN.
REQ-032 Defined: in IDLE with memen=1, misalignment asserts the error flag combinationally, issues no request, and keeps stall=0.
- Misaligned means LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
- Loads assert adel; stores assert ades.
REQ-033 Undefined: adel=ades=0 constantly; low address bits are forced to alignment (half: bit0=0; word: bits1:0=0) and the access proceeds normally.

Verification
REQ-034 LW addr=0x100, addr_ok and data_ok both in cycle T+1, data_rdata=0xDEADBEEF -> stall high 2 cycles, rdata=0xDEADBEEF at T+2.
REQ-035 LB addr=0x103, data_rdata=0x80112233 -> rdata=0xFFFFFF80; LBU same access -> 0x00000080; LH addr=0x102 -> 0xFFFF8011.
REQ-036 SB addr=0x201, wdata=0x000000AB -> data_wstrb=0010, data_wdata=0xABABABAB, data_wr=1, data_size=0.
REQ-037 Load with addr_ok at T+1, flush at T+2, data_ok at T+5 -> DRAIN, stall high through T+5, rdata unchanged, IDLE at T+6.
REQ-038 With MEM_ALIGN_CHECK_EN, LW addr=0x102 -> adel=1, data_req never asserted, stall=0; without macro -> data_addr=0x100.
REQ-039 rst driven low while in WAIT -> all outputs at reset values immediately (asynchronously); next memen starts a fresh REQ.
